status_unit: RTL and testbench



---
 rtl/status_unit.sv | 55 +++++
 tb/tb_status_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/status_unit.sv
// Architectural {N,Z,C,V} flag register with exception snapshot and ID->EX flag hazard tracking.
// Build option: STATUS_BYPASS_EN forwards EX flags into status instead of stalling ID.
module status_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       freeze,
  input  logic       flush,
  input  logic       id_s,
  input  logic [3:0] id_cond,
  input  logic [3:0] ex_alu_status,
  input  logic       save,
  input  logic       restore,
  output logic [3:0] status,
  output logic [3:0] saved_status,
  output logic       hazard
);

  logic [3:0] sr;
  logic [3:0] snap;
  logic       ex_s;
  logic       uses_flags;

  // 1110 and 1111 both mean "always": no flag dependency
  assign uses_flags = (id_cond != 4'b1110) && (id_cond != 4'b1111);

`ifdef STATUS_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = uses_flags;
  assign status = ex_s ? ex_alu_status : sr;
  assign hazard = 1'b0;
`else
  assign status = sr;
  assign hazard = ex_s && uses_flags && !freeze;
`endif

  assign saved_status = snap;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= 4'b0000;
      snap <= 4'b0000;
      ex_s <= 1'b0;
    end else if (!freeze) begin
      // a stall or squash sends a bubble into EX; the EX instruction still retires its flags
      ex_s <= (flush || hazard) ? 1'b0 : id_s;
      if (restore)
        sr <= snap;
      else if (ex_s)
        sr <= ex_alu_status;
      if (save && !restore)
        snap <= status;
    end
  end

endmodule

// File: tb/tb_status_unit.sv
// Scoreboard bench for status_unit: per-cycle stimulus tables, expectations queued at drive time.
module tb_status_unit;

`ifdef STATUS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, freeze, flush, id_s, save, restore;
  logic [3:0] id_cond, ex_alu_status;
  logic [3:0] status, saved_status;
  logic       hazard;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst, fr, fl, ids;
    logic [3:0] cond, alu;
    logic       sv, rs;
    logic [3:0] stn, stb, esv;  // expected status (normal / bypass build), expected snapshot
    logic       hzn;            // expected hazard in the normal build
  } stim_t;

  typedef struct {
    logic [3:0] st, sv;
    logic       hz;
  } exp_t;

  exp_t sb[$];

  status_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_s(id_s),
    .id_cond(id_cond), .ex_alu_status(ex_alu_status), .save(save), .restore(restore),
    .status(status), .saved_status(saved_status), .hazard(hazard)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic apply(input stim_t s);
    exp_t e;
    rst = s.rst; freeze = s.fr; flush = s.fl; id_s = s.ids;
    id_cond = s.cond; ex_alu_status = s.alu; save = s.sv; restore = s.rs;
    e.st = BYP ? s.stb : s.stn;
    e.sv = s.esv;
    e.hz = BYP ? 1'b0 : s.hzn;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    stim_t t[2];
    exp_t  e;
    rst = 1'b1; freeze = 1'b1; flush = 1'b1; id_s = 1'b1; id_cond = 4'b0000;
    ex_alu_status = 4'b1111; save = 1'b1; restore = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    t[0] = '{1'b1,1'b1,1'b1,1'b1,4'b0000,4'b1111,1'b1,1'b1, 4'b0000,4'b0000,4'b0000,1'b0};
    t[1] = '{1'b0,1'b0,1'b0,1'b0,4'b1110,4'b1111,1'b0,1'b0, 4'b0000,4'b0000,4'b0000,1'b0};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({status, saved_status, hazard} !== {e.st, e.sv, e.hz}) begin
        errors++;
        $display("FAIL reset[%0d]: got st=%b sv=%b hz=%b, want st=%b sv=%b hz=%b",
                 i, status, saved_status, hazard, e.st, e.sv, e.hz);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_update();
    stim_t t[3];
    exp_t  e;
    t[0] = '{1'b0,1'b0,1'b0,1'b1,4'b1110,4'b0000,1'b0,1'b0, 4'b0000,4'b0000,4'b0000,1'b0};
    t[1] = '{1'b0,1'b0,1'b0,1'b0,4'b0000,4'b0100,1'b0,1'b0, 4'b0000,4'b0100,4'b0000,1'b1};
    t[2] = '{1'b0,1'b0,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0, 4'b0100,4'b0100,4'b0000,1'b0};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({status, saved_status, hazard} !== {e.st, e.sv, e.hz}) begin
        errors++;
        $display("FAIL update[%0d]: got st=%b sv=%b hz=%b, want st=%b sv=%b hz=%b",
                 i, status, saved_status, hazard, e.st, e.sv, e.hz);
      end
      @(posedge clk); #1;
    end
  endtask

  // back-to-back setters, also exercising both "always" condition codes with ex_s=1
  task automatic test_back_to_back();
    stim_t t[4];
    exp_t  e;
    t[0] = '{1'b0,1'b0,1'b0,1'b1,4'b1110,4'b0000,1'b0,1'b0, 4'b0100,4'b0100,4'b0000,1'b0};
    t[1] = '{1'b0,1'b0,1'b0,1'b1,4'b1111,4'b0001,1'b0,1'b0, 4'b0100,4'b0001,4'b0000,1'b0};
    t[2] = '{1'b0,1'b0,1'b0,1'b0,4'b1110,4'b1010,1'b0,1'b0, 4'b0001,4'b1010,4'b0000,1'b0};
    t[3] = '{1'b0,1'b0,1'b0,1'b0,4'b1110,4'b0000,1'b0,1'b0, 4'b1010,4'b1010,4'b0000,1'b0};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({status, saved_status, hazard} !== {e.st, e.sv, e.hz}) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got st=%b sv=%b hz=%b, want st=%b sv=%b hz=%b",
                 i, status, saved_status, hazard, e.st, e.sv, e.hz);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    stim_t t[6];
    exp_t  e;
    t[0] = '{1'b0,1'b0,1'b1,1'b1,4'b1110,4'b0000,1'b0,1'b0, 4'b1010,4'b1010,4'b0000,1'b0};
    t[1] = '{1'b0,1'b0,1'b0,1'b0,4'b1110,4'b1111,1'b0,1'b0, 4'b1010,4'b1010,4'b0000,1'b0};
    t[2] = '{1'b0,1'b0,1'b0,1'b0,4'b1110,4'b1111,1'b0,1'b0, 4'b1010,4'b1010,4'b0000,1'b0};
    t[3] = '{1'b0,1'b0,1'b0,1'b1,4'b1110,4'b0000,1'b0,1'b0, 4'b1010,4'b1010,4'b0000,1'b0};
    t[4] = '{1'b0,1'b0,1'b1,1'b1,4'b1110,4'b0110,1'b0,1'b0, 4'b1010,4'b0110,4'b0000,1'b0};
    t[5] = '{1'b0,1'b0,1'b0,1'b0,4'b1110,4'b1111,1'b0,1'b0, 4'b0110,4'b0110,4'b0000,1'b0};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({status, saved_status, hazard} !== {e.st, e.sv, e.hz}) begin
        errors++;
        $display("FAIL flush[%0d]: got st=%b sv=%b hz=%b, want st=%b sv=%b hz=%b",
                 i, status, saved_status, hazard, e.st, e.sv, e.hz);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_freeze();
    stim_t t[8];
    exp_t  e;
    t[0] = '{1'b0,1'b0,1'b0,1'b1,4'b1110,4'b0000,1'b0,1'b0, 4'b0110,4'b0110,4'b0000,1'b0};
    t[1] = '{1'b0,1'b0,1'b0,1'b0,4'b1110,4'b0010,1'b0,1'b0, 4'b0110,4'b0010,4'b0000,1'b0};
    t[2] = '{1'b0,1'b0,1'b0,1'b1,4'b1110,4'b0000,1'b0,1'b0, 4'b0010,4'b0010,4'b0000,1'b0};
    t[3] = '{1'b0,1'b1,1'b0,1'b0,4'b0000,4'b1000,1'b0,1'b0, 4'b0010,4'b1000,4'b0000,1'b0};
    t[4] = '{1'b0,1'b1,1'b0,1'b0,4'b0000,4'b1000,1'b0,1'b0, 4'b0010,4'b1000,4'b0000,1'b0};
    t[5] = '{1'b0,1'b1,1'b0,1'b0,4'b0000,4'b1000,1'b0,1'b0, 4'b0010,4'b1000,4'b0000,1'b0};
    t[6] = '{1'b0,1'b0,1'b0,1'b0,4'b0000,4'b1000,1'b0,1'b0, 4'b0010,4'b1000,4'b0000,1'b1};
    t[7] = '{1'b0,1'b0,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b0, 4'b1000,4'b1000,4'b0000,1'b0};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({status, saved_status, hazard} !== {e.st, e.sv, e.hz}) begin
        errors++;
        $display("FAIL freeze[%0d]: got st=%b sv=%b hz=%b, want st=%b sv=%b hz=%b",
                 i, status, saved_status, hazard, e.st, e.sv, e.hz);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_snapshot();
    stim_t t[11];
    exp_t  e;
    t[0]  = '{1'b0,1'b0,1'b0,1'b1,4'b1110,4'b0000,1'b0,1'b0, 4'b1000,4'b1000,4'b0000,1'b0};
    t[1]  = '{1'b0,1'b0,1'b0,1'b0,4'b1110,4'b1001,1'b0,1'b0, 4'b1000,4'b1001,4'b0000,1'b0};
    t[2]  = '{1'b0,1'b0,1'b0,1'b0,4'b1110,4'b0000,1'b1,1'b0, 4'b1001,4'b1001,4'b0000,1'b0};
    t[3]  = '{1'b0,1'b0,1'b0,1'b1,4'b1110,4'b0000,1'b0,1'b0, 4'b1001,4'b1001,4'b1001,1'b0};
    t[4]  = '{1'b0,1'b0,1'b0,1'b0,4'b1110,4'b0000,1'b0,1'b0, 4'b1001,4'b0000,4'b1001,1'b0};
    t[5]  = '{1'b0,1'b0,1'b0,1'b0,4'b1110,4'b0000,1'b0,1'b1, 4'b0000,4'b0000,4'b1001,1'b0};
    t[6]  = '{1'b0,1'b0,1'b0,1'b0,4'b1110,4'b0000,1'b0,1'b0, 4'b1001,4'b1001,4'b1001,1'b0};
    t[7]  = '{1'b0,1'b0,1'b0,1'b1,4'b1110,4'b0000,1'b0,1'b0, 4'b1001,4'b1001,4'b1001,1'b0};
    t[8]  = '{1'b0,1'b0,1'b0,1'b0,4'b1110,4'b0011,1'b0,1'b0, 4'b1001,4'b0011,4'b1001,1'b0};
    t[9]  = '{1'b0,1'b0,1'b0,1'b0,4'b1110,4'b0000,1'b1,1'b1, 4'b0011,4'b0011,4'b1001,1'b0};
    t[10] = '{1'b0,1'b0,1'b0,1'b0,4'b1110,4'b0000,1'b0,1'b0, 4'b1001,4'b1001,4'b1001,1'b0};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({status, saved_status, hazard} !== {e.st, e.sv, e.hz}) begin
        errors++;
        $display("FAIL snapshot[%0d]: got st=%b sv=%b hz=%b, want st=%b sv=%b hz=%b",
                 i, status, saved_status, hazard, e.st, e.sv, e.hz);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    stim_t t[3];
    exp_t  e;
    t[0] = '{1'b0,1'b0,1'b0,1'b1,4'b1110,4'b0000,1'b0,1'b0, 4'b1001,4'b1001,4'b1001,1'b0};
    t[1] = '{1'b1,1'b0,1'b0,1'b0,4'b1110,4'b1111,1'b0,1'b0, 4'b1001,4'b1111,4'b1001,1'b0};
    t[2] = '{1'b0,1'b0,1'b0,1'b0,4'b1110,4'b1111,1'b0,1'b0, 4'b0000,4'b0000,4'b0000,1'b0};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({status, saved_status, hazard} !== {e.st, e.sv, e.hz}) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got st=%b sv=%b hz=%b, want st=%b sv=%b hz=%b",
                 i, status, saved_status, hazard, e.st, e.sv, e.hz);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_update();
    test_back_to_back();
    test_flush();
    test_freeze();
    test_snapshot();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
